wbmem_pipe: RTL and testbench

- Parametrised on-chip Wishbone (pipelined, B4) memory; successor to the single-cycle block RAM slave.
- Adds configurable depth (not restricted to a power of two) and byte-lane write enables.
- Adds a selectable read latency of 1 or 2 cycles and synchronous reset of the response path.
- Adds abort-on-CYC-drop; sits on the main bus beside the flash/peripheral slaves as CPU scratch/program RAM.

---
 rtl/wbmem_pkg.sv | 16 +
 rtl/wb_resp_pipe.sv | 36 +++
 rtl/wbmem_pipe.sv | 97 +++++++++
 tb/tb_wbmem_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wbmem_pkg.sv
// Shared constants and types for the pipelined Wishbone memory and its response pipe.
package wbmem_pkg;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 2;

   function automatic int lane_cnt(input int dw);
      return dw / 8;
   endfunction

   typedef struct packed {
      logic vld;
      logic err;
   } resp_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// LAT-deep {valid, err} response shift register; a CYC drop or reset empties it
// so aborted requests never produce a response.
module wb_resp_pipe
   import wbmem_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_cyc,
   input  logic i_push,
   input  logic i_err,
   output logic o_ack,
   output logic o_err
);

   resp_t          in_ent;
   resp_t [LAT:1]  vld_pipe;

   assign in_ent = '{vld: i_push, err: i_err};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_cyc) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_ent;
         for (int s = 2; s <= LAT; s++)
            vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   // err entries never raise ack, keeping the two strobes exclusive
   assign o_ack = vld_pipe[LAT].vld && !vld_pipe[LAT].err;
   assign o_err = vld_pipe[LAT].vld &&  vld_pipe[LAT].err;

endmodule

// File: rtl/wbmem_pipe.sv
// Pipelined Wishbone B4 on-chip RAM with byte-lane writes and 1- or 2-cycle read latency.
// Define WBMEM_ERR_EN to answer out-of-range accesses with o_wb_err instead of a zero-data ack.
module wbmem_pipe
   import wbmem_pkg::*;
#(
   parameter int AW    = 15,
   parameter int DW    = 32,
   parameter int DEPTH = 1 << AW,
   parameter int LAT   = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [AW-1:0]   i_wb_addr,
   input  logic [DW-1:0]   i_wb_data,
   input  logic [DW/8-1:0] i_wb_sel,
   output logic            o_wb_ack,
   output logic            o_wb_stall,
   output logic [DW-1:0]   o_wb_data,
   output logic            o_wb_err
);

   localparam int NL    = lane_cnt(DW);
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LAT_C = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

   logic          accept;
   logic          in_range;
   logic          wr_en;
   logic          err_in;
   logic [IW-1:0] idx;
   logic [DW-1:0] rd_word;

   assign accept   = i_wb_cyc && i_wb_stb;
   assign in_range = (64'(i_wb_addr) < 64'(DEPTH));
   assign idx      = i_wb_addr[IW-1:0];
   // a write coinciding with reset is dropped
   assign wr_en    = i_rst_n && accept && i_wb_we && in_range;

`ifdef WBMEM_ERR_EN
   assign err_in = !in_range;
`else
   assign err_in = 1'b0;
`endif

   // one byte-wide array per lane so each lane infers its own RAM with a write enable
   for (genvar n = 0; n < NL; n++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_q;

      always_ff @(posedge i_clk) begin
         if (wr_en && i_wb_sel[n])
            mem[idx] <= i_wb_data[8*n +: 8];
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n)
            rd_q <= '0;
         else if (accept)
            rd_q <= in_range ? mem[idx] : 8'h00;
      end

      assign rd_word[8*n +: 8] = rd_q;
   end

   if (LAT_C == 2) begin : g_lat2
      logic [DW-1:0] dat_q;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n)
            dat_q <= '0;
         else
            dat_q <= rd_word;
      end

      assign o_wb_data = dat_q;
   end else begin : g_lat1
      assign o_wb_data = rd_word;
   end

   wb_resp_pipe #(
      .LAT(LAT_C)
   ) u_resp (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_cyc  (i_wb_cyc),
      .i_push (accept),
      .i_err  (err_in),
      .o_ack  (o_wb_ack),
      .o_err  (o_wb_err)
   );

   assign o_wb_stall = 1'b0;

endmodule

// File: tb/tb_wbmem_pipe.sv
// Bench for wbmem_pipe: a LAT=1 and a LAT=2 instance (DEPTH=1000, AW=10) share the same
// bus stimulus and are compared against a queue-based response model.
module tb_wbmem_pipe;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1000;
`ifdef WBMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, cyc, stb, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdat;
   logic [3:0]    sel;
   logic          ack1, stall1, err1, ack2, stall2, err2;
   logic [DW-1:0] dat1, dat2;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   typedef struct {
      int          due;
      bit          err;
      logic [31:0] data;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   logic [31:0] mem_m [0:1023];

   always #5 clk = ~clk;

   wbmem_pipe #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LAT(1)) u_l1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
      .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_data(dat1), .o_wb_err(err1)
   );

   wbmem_pipe #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LAT(2)) u_l2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
      .o_wb_ack(ack2), .o_wb_stall(stall2), .o_wb_data(dat2), .o_wb_err(err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, advance the model at the edge, then compare both instances.
   task automatic step(input bit r, input bit c, input bit s, input bit w,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
      bit          inr;
      logic [31:0] rd;
      exp_t        e;
      bit          ev1, ee1, ev2, ee2;
      logic [31:0] ed1, ed2;
      rst_n = r; cyc = c; stb = s; we = w; addr = a; wdat = d; sel = sl;
      @(posedge clk);
      cyc_n++;
      if (!r || !c) begin
         q1.delete();
         q2.delete();
      end else if (s) begin
         inr = (int'(a) < DEPTH);
         rd  = inr ? mem_m[a] : 32'h0;
         q1.push_back('{due: cyc_n,     err: ERR_EN && !inr, data: rd});
         q2.push_back('{due: cyc_n + 1, err: ERR_EN && !inr, data: rd});
         if (w && inr)
            for (int b = 0; b < 4; b++)
               if (sl[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
      end
      ev1 = 0; ee1 = 0; ed1 = '0;
      ev2 = 0; ee2 = 0; ed2 = '0;
      if (q1.size() > 0 && q1[0].due == cyc_n) begin
         e = q1.pop_front(); ev1 = !e.err; ee1 = e.err; ed1 = e.data;
      end
      if (q2.size() > 0 && q2[0].due == cyc_n) begin
         e = q2.pop_front(); ev2 = !e.err; ee2 = e.err; ed2 = e.data;
      end
      #1;
      chk("l1_ack",   32'(ack1),   32'(ev1));
      chk("l1_err",   32'(err1),   32'(ee1));
      chk("l1_stall", 32'(stall1), 32'(0));
      chk("l2_ack",   32'(ack2),   32'(ev2));
      chk("l2_err",   32'(err2),   32'(ee2));
      chk("l2_stall", 32'(stall2), 32'(0));
      if (ev1) chk("l1_data", dat1, ed1);
      if (ev2) chk("l2_data", dat2, ed2);
      if (!r) begin
         chk("l1_rst_data", dat1, 32'h0);
         chk("l2_rst_data", dat2, 32'h0);
      end
   endtask

   initial begin
      logic [AW-1:0] ra;
      rst_n = 0; cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;

      // reset values
      step(0, 0, 0, 0, 10'd0, 32'h0, 4'h0);
      step(0, 0, 0, 0, 10'd0, 32'h0, 4'h0);

      // fill every in-range word so later reads are defined
      for (int i = 0; i < DEPTH; i++)
         step(1, 1, 1, 1, 10'(i), $urandom, 4'hF);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);

      // write then read back
      step(1, 1, 1, 1, 10'd5, 32'hDEADBEEF, 4'hF);
      step(1, 1, 1, 0, 10'd5, 32'h0, 4'h0);
      chk("wr_rd_l1", dat1, 32'hDEADBEEF);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      chk("wr_rd_l2", dat2, 32'hDEADBEEF);

      // byte lanes
      step(1, 1, 1, 1, 10'd5, 32'h11223344, 4'b0101);
      step(1, 1, 1, 0, 10'd5, 32'h0, 4'h0);
      chk("lane_l1", dat1, 32'hDE22BE44);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      chk("lane_l2", dat2, 32'hDE22BE44);

      // back-to-back burst
      for (int i = 0; i < 4; i++)
         step(1, 1, 1, 0, 10'(i), 32'h0, 4'h0);
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);

      // abort: write, three reads, drop CYC, idle, then read the write back
      step(1, 1, 1, 1, 10'd7, 32'hA5A5_5A5A, 4'hF);
      for (int i = 0; i < 3; i++)
         step(1, 1, 1, 0, 10'(i), 32'h0, 4'h0);
      step(1, 0, 0, 0, 10'd0, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      step(1, 1, 1, 0, 10'd7, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);

      // out of range, zero-select write, STB without CYC
      step(1, 1, 1, 0, 10'd1000, 32'h0, 4'h0);
      step(1, 1, 1, 1, 10'd1023, 32'hFFFF_FFFF, 4'hF);
      step(1, 1, 1, 1, 10'd9, 32'h1234_5678, 4'h0);
      step(1, 0, 1, 1, 10'd9, 32'h0BAD_0BAD, 4'hF);
      step(1, 1, 1, 0, 10'd9, 32'h0, 4'h0);
      step(1, 1, 1, 0, 10'd999, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);

      // reset with a read in flight and a write presented on the reset edge
      step(1, 1, 1, 0, 10'd5, 32'h0, 4'h0);
      step(0, 1, 1, 1, 10'd5, 32'h0, 4'hF);
      step(1, 1, 1, 0, 10'd5, 32'h0, 4'h0);
      chk("post_rst_l1", dat1, 32'hDE22BE44);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      chk("post_rst_l2", dat2, 32'hDE22BE44);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                          : 10'($urandom_range(0, 999));
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ra, $urandom, 4'($urandom_range(0, 15)));
      end
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);
      step(1, 1, 0, 0, 10'd0, 32'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
